// File: rtl/md_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide execute unit.
//   md_op_t       : E-stage multiply/divide opcode (7 is reserved, acts as NONE)
//   md_read_sel_t : MFHI/MFLO read select (3 is reserved, acts as none)
//   md_state_t    : sequencer state
//   mul_cycles / div_cycles : iteration counts loaded into the step counter
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_HI   = 2'd1,
    RD_LO   = 2'd2,
    RD_RSVD = 2'd3
  } md_read_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_t;

  function automatic int mul_cycles(input int xlen, input int bpc);
    return xlen / bpc;
  endfunction

  function automatic int div_cycles(input int xlen);
    return xlen;
  endfunction

endpackage

// File: rtl/execute_muldiv_if.sv
// E-stage <-> multiply/divide unit bundle.
//   master : E stage (drives request, forwarded operands, cancel)
//   slave  : execute_muldiv (drives read data, HI/LO, stall/busy/done)
interface execute_muldiv_if #(parameter int XLEN = 32) ();
  logic            valid_e_i;
  logic            flush_e_i;
  logic            cancel_i;
  logic [2:0]      md_op_e_i;
  logic [1:0]      md_read_sel_e_i;
  logic [XLEN-1:0] src_a_e_i;
  logic [XLEN-1:0] src_b_e_i;
  logic [XLEN-1:0] md_result_e_o;
  logic [XLEN-1:0] hi_o;
  logic [XLEN-1:0] lo_o;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;

  modport master (
    output valid_e_i, flush_e_i, cancel_i, md_op_e_i, md_read_sel_e_i,
           src_a_e_i, src_b_e_i,
    input  md_result_e_o, hi_o, lo_o, stall_o, busy_o, done_o
  );

  modport slave (
    input  valid_e_i, flush_e_i, cancel_i, md_op_e_i, md_read_sel_e_i,
           src_a_e_i, src_b_e_i,
    output md_result_e_o, hi_o, lo_o, stall_o, busy_o, done_o
  );
endinterface

// File: rtl/muldiv_core.sv
// Iterative multiply/divide datapath.
//   start      : latch operands for op (MULT/MULTU/DIV/DIVU), load counter
//   step       : retire one iteration (mul: MUL_BITS_PER_CYCLE bits, div: 1 bit)
//   cnt_last   : counter == 1, this step is the final one
//   res_hi/lo  : sign-corrected result, combinational from internal regs
// One 2*XLEN accumulator serves both ops: mul keeps {partial, multiplier},
// div keeps {remainder, dividend/quotient} shifting left.
module muldiv_core
  import md_pkg::*;
#(
  parameter int XLEN               = 32,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  md_op_t          op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            step,
  output logic            cnt_last,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);
  localparam int BPC = MUL_BITS_PER_CYCLE;
  localparam int CW  = $clog2(XLEN + 1);
  localparam int PPW = XLEN + BPC;
  localparam logic [CW-1:0] MUL_CNT = CW'(mul_cycles(XLEN, BPC));
  localparam logic [CW-1:0] DIV_CNT = CW'(div_cycles(XLEN));

  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;    // multiplicand or divisor magnitude
  logic [XLEN-1:0]   a_orig;  // raw dividend, returned as HI on divide-by-zero
  logic [CW-1:0]     cnt;
  logic              is_mul, neg_hi, neg_lo, dz;

  logic              sgn, a_neg, b_neg, st_mul;
  logic [XLEN-1:0]   a_mag, b_mag;

  always_comb begin
    sgn    = (op == MD_MULT) || (op == MD_DIV);
    st_mul = (op == MD_MULT) || (op == MD_MULTU);
    a_neg  = sgn & src_a[XLEN-1];
    b_neg  = sgn & src_b[XLEN-1];
    a_mag  = a_neg ? -src_a : src_a;
    b_mag  = b_neg ? -src_b : src_b;
  end

  // shift-add: {hi + mcand*digit, lo} >> BPC
  logic [PPW-1:0]    pp, mul_upper;
  logic [2*XLEN-1:0] mul_nxt;

  always_comb begin
    pp = '0;
    for (int i = 0; i < BPC; i++)
      if (acc[i]) pp = pp + (PPW'(opnd) << i);
    mul_upper = PPW'(acc[2*XLEN-1:XLEN]) + pp;
    mul_nxt   = {mul_upper, acc[XLEN-1:BPC]};
  end

  // restoring step: shift next dividend bit into remainder, trial subtract
  logic [XLEN:0]     rem_sh, diff;
  logic [2*XLEN-1:0] div_nxt;

  always_comb begin
    rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff    = rem_sh - {1'b0, opnd};
    div_nxt = diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                         : {diff[XLEN-1:0],   acc[XLEN-2:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc    <= '0;
      opnd   <= '0;
      a_orig <= '0;
      cnt    <= '0;
      is_mul <= 1'b0;
      neg_hi <= 1'b0;
      neg_lo <= 1'b0;
      dz     <= 1'b0;
    end else if (start) begin
      acc    <= {{XLEN{1'b0}}, a_mag};
      opnd   <= b_mag;
      a_orig <= src_a;
      cnt    <= st_mul ? MUL_CNT : DIV_CNT;
      is_mul <= st_mul;
      neg_lo <= a_neg ^ b_neg;                    // product / quotient sign
      neg_hi <= st_mul ? (a_neg ^ b_neg) : a_neg; // remainder follows dividend
      dz     <= ~st_mul & (src_b == '0);
    end else if (step) begin
      acc <= is_mul ? mul_nxt : div_nxt;
      cnt <= cnt - 1'b1;
    end
  end

  assign cnt_last = (cnt == CW'(1));

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   rem_fix, quo_fix;

  always_comb begin
    prod_fix = neg_lo ? -acc : acc;
    rem_fix  = neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    quo_fix  = neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    if (is_mul) begin
      res_hi = prod_fix[2*XLEN-1:XLEN];
      res_lo = prod_fix[XLEN-1:0];
    end else if (dz) begin
      res_hi = a_orig;
      res_lo = '1;
    end else begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end
  end
endmodule

// File: rtl/execute_muldiv.sv
// Multi-cycle HI/LO multiply/divide unit for the execute stage.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : E-stage request (valid/flush/cancel, op, read select,
//                  forwarded operands) and responses (MFHI/MFLO data,
//                  HI/LO, stall to hazard unit, busy, done pulse)
// Sequencer IDLE -> MUL/DIV -> FIX -> IDLE owns HI/LO; the datapath lives in
// muldiv_core. MTHI/MTLO write directly from IDLE without occupying the unit.
module execute_muldiv
  import md_pkg::*;
#(
  parameter int XLEN               = 32,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  execute_muldiv_if.slave bus
);
  md_state_t       state;
  logic [XLEN-1:0] hi_q, lo_q;
  logic            done_q;

  md_op_t          op;
  md_read_sel_t    sel;
  logic            acc_e, is_md, start, op_real, rd_real, busy, step, cnt_last;
  logic [XLEN-1:0] res_hi, res_lo;

  assign op      = md_op_t'(bus.md_op_e_i);
  assign sel     = md_read_sel_t'(bus.md_read_sel_e_i);
  assign acc_e   = bus.valid_e_i & ~bus.flush_e_i;
  assign is_md   = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  assign op_real = (op != MD_NONE) && (op != MD_RSVD);
  assign rd_real = (sel == RD_HI) || (sel == RD_LO);
  assign busy    = (state != ST_IDLE);
  assign start   = (state == ST_IDLE) & acc_e & is_md;
  assign step    = (state == ST_MUL) || (state == ST_DIV);

  muldiv_core #(
    .XLEN               (XLEN),
    .MUL_BITS_PER_CYCLE (MUL_BITS_PER_CYCLE)
  ) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .src_a    (bus.src_a_e_i),
    .src_b    (bus.src_b_e_i),
    .step     (step),
    .cnt_last (cnt_last),
    .res_hi   (res_hi),
    .res_lo   (res_lo)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // cancel is ignored here so it never blocks a same-cycle accept
          if (acc_e) begin
            case (op)
              MD_MULT, MD_MULTU: state <= ST_MUL;
              MD_DIV,  MD_DIVU:  state <= ST_DIV;
              MD_MTHI:           hi_q  <= bus.src_a_e_i;
              MD_MTLO:           lo_q  <= bus.src_a_e_i;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (bus.cancel_i)  state <= ST_IDLE;
          else if (cnt_last) state <= ST_FIX;
        end
        ST_FIX: begin
          state <= ST_IDLE;
          // a cancel landing on the fix cycle still wins over the write
          if (!bus.cancel_i) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // the starting instruction sees busy=0, so it is never stalled itself
  assign bus.stall_o = busy & acc_e & (op_real | rd_real);
  assign bus.busy_o  = busy;
  assign bus.done_o  = done_q;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;
  assign bus.md_result_e_o = (sel == RD_HI) ? hi_q :
                             (sel == RD_LO) ? lo_q : '0;
endmodule

// File: tb/tb_execute_muldiv.sv
module tb_execute_muldiv;
  import md_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  execute_muldiv_if #(.XLEN(32)) bus ();
  execute_muldiv_if #(.XLEN(32)) bus4 ();

  execute_muldiv #(.XLEN(32), .MUL_BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave));
  execute_muldiv #(.XLEN(32), .MUL_BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4.slave));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    bus.valid_e_i = 0;  bus.flush_e_i = 0;  bus.cancel_i = 0;
    bus.md_op_e_i = 0;  bus.md_read_sel_e_i = 0;
    bus.src_a_e_i = 0;  bus.src_b_e_i = 0;
    bus4.valid_e_i = 0; bus4.flush_e_i = 0; bus4.cancel_i = 0;
    bus4.md_op_e_i = 0; bus4.md_read_sel_e_i = 0;
    bus4.src_a_e_i = 0; bus4.src_b_e_i = 0;
  endtask

  // Issue op, follow with a held MFLO, count stalled cycles until the write.
  task automatic run_md(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    int early;
    tick;
    bus.valid_e_i = 1; bus.md_op_e_i = op; bus.src_a_e_i = a; bus.src_b_e_i = b;
    @(negedge clk);
    chk({tag, "_start_nostall"}, bus.stall_o, 0);
    tick;
    bus.md_op_e_i = MD_NONE; bus.md_read_sel_e_i = RD_LO;
    cyc = 0; early = 0;
    @(negedge clk);
    while (bus.stall_o && cyc < 100) begin
      if (bus.done_o) early++;
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_stall_cycles"}, cyc, 33);
    chk({tag, "_early_done"}, early, 0);
    chk({tag, "_done"}, bus.done_o, 1);
    chk({tag, "_mflo"}, bus.md_result_e_o, exp_lo);
    chk({tag, "_hi"}, bus.hi_o, exp_hi);
    chk({tag, "_lo"}, bus.lo_o, exp_lo);
    tick;
    idle_in();
    @(negedge clk);
    chk({tag, "_done_single"}, bus.done_o, 0);
  endtask

  initial begin
    int n;
    idle_in();
    reset_n = 0;
    tick; tick;
    @(negedge clk);
    chk("rst_hi", bus.hi_o, 0);
    chk("rst_lo", bus.lo_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    tick;
    reset_n = 1;

    // MTHI / MTLO then immediate read, no stall
    tick;
    bus.valid_e_i = 1; bus.md_op_e_i = MD_MTHI; bus.src_a_e_i = 32'h12345678;
    tick;
    bus.md_op_e_i = MD_NONE; bus.md_read_sel_e_i = RD_HI;
    @(negedge clk);
    chk("mfhi_nostall", bus.stall_o, 0);
    chk("mfhi_data", bus.md_result_e_o, 32'h12345678);
    tick;
    bus.md_op_e_i = MD_MTLO; bus.md_read_sel_e_i = RD_NONE; bus.src_a_e_i = 32'hCAFEF00D;
    tick;
    bus.md_op_e_i = MD_NONE; bus.md_read_sel_e_i = RD_LO;
    @(negedge clk);
    chk("mflo_data", bus.md_result_e_o, 32'hCAFEF00D);
    chk("mt_busy", bus.busy_o, 0);
    tick;
    idle_in();

    // MULT then independent/reserved traffic, dependent read, cancel at cycle 10
    tick;
    bus.valid_e_i = 1; bus.md_op_e_i = MD_MULT; bus.src_a_e_i = 5; bus.src_b_e_i = 6;
    tick;
    bus.md_op_e_i = MD_NONE;
    @(negedge clk);
    chk("indep_nostall", bus.stall_o, 0);
    chk("mult_busy", bus.busy_o, 1);
    tick;
    bus.md_op_e_i = MD_RSVD;
    @(negedge clk);
    chk("rsvd_op_nostall", bus.stall_o, 0);
    tick;
    bus.md_op_e_i = MD_NONE; bus.md_read_sel_e_i = RD_RSVD;
    @(negedge clk);
    chk("rsvd_sel_nostall", bus.stall_o, 0);
    tick;
    bus.md_read_sel_e_i = RD_HI;
    @(negedge clk);
    chk("mfhi_busy_stall", bus.stall_o, 1);
    tick;
    idle_in();
    repeat (5) tick;
    bus.cancel_i = 1;
    tick;
    bus.cancel_i = 0;
    @(negedge clk);
    chk("cancel_busy", bus.busy_o, 0);
    chk("cancel_hi", bus.hi_o, 32'h12345678);
    chk("cancel_lo", bus.lo_o, 32'hCAFEF00D);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o) n++;
    end
    chk("cancel_no_done", n, 0);

    // cancel in IDLE does not block accept; cancel in FIX beats the write
    tick;
    bus.valid_e_i = 1; bus.md_op_e_i = MD_MULT; bus.src_a_e_i = 2; bus.src_b_e_i = 3;
    bus.cancel_i = 1;
    tick;
    idle_in();
    @(negedge clk);
    chk("cancel_idle_accept", bus.busy_o, 1);
    repeat (32) tick;
    bus.cancel_i = 1;
    tick;
    bus.cancel_i = 0;
    @(negedge clk);
    chk("cancel_fix_done", bus.done_o, 0);
    chk("cancel_fix_busy", bus.busy_o, 0);
    chk("cancel_fix_lo", bus.lo_o, 32'hCAFEF00D);

    run_md("mult",   MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_md("multu",  MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_md("div",    MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("divu0",  MD_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF);
    run_md("divovf", MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_md("divs0",  MD_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);

    // 4 bits/cycle instance: 8 steps + fix
    tick;
    bus4.valid_e_i = 1; bus4.md_op_e_i = MD_MULTU;
    bus4.src_a_e_i = 32'hFFFFFFFF; bus4.src_b_e_i = 32'hFFFFFFFF;
    tick;
    idle_in();
    n = 0;
    @(negedge clk);
    while (bus4.busy_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("mul4_cycles", n, 9);
    chk("mul4_done", bus4.done_o, 1);
    chk("mul4_hi", bus4.hi_o, 32'hFFFFFFFE);
    chk("mul4_lo", bus4.lo_o, 32'h00000001);

    // flushed MULT is not started
    tick;
    bus.valid_e_i = 1; bus.flush_e_i = 1; bus.md_op_e_i = MD_MULT;
    bus.src_a_e_i = 3; bus.src_b_e_i = 4;
    tick;
    idle_in();
    @(negedge clk);
    chk("flush_busy", bus.busy_o, 0);

    // back-to-back DIV: second held stalled, starts right after the first writes
    tick;
    bus.valid_e_i = 1; bus.md_op_e_i = MD_DIV; bus.src_a_e_i = 100; bus.src_b_e_i = 7;
    tick;
    bus.md_op_e_i = MD_DIVU; bus.src_a_e_i = 32'hFFFFFFFF; bus.src_b_e_i = 16;
    n = 0;
    @(negedge clk);
    while (bus.stall_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_stall_cycles", n, 33);
    chk("b2b_first_lo", bus.lo_o, 14);
    chk("b2b_first_hi", bus.hi_o, 2);
    chk("b2b_first_idle", bus.busy_o, 0);
    tick;
    idle_in();
    @(negedge clk);
    chk("b2b_second_start", bus.busy_o, 1);
    n = 0;
    while (bus.busy_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_second_cycles", n, 33);
    chk("b2b_second_lo", bus.lo_o, 32'h0FFFFFFF);
    chk("b2b_second_hi", bus.hi_o, 32'h0000000F);

    // reset mid-DIV discards the op and clears HI/LO
    tick;
    bus.valid_e_i = 1; bus.md_op_e_i = MD_DIV; bus.src_a_e_i = 32'hFFFFFFF9; bus.src_b_e_i = 2;
    tick;
    idle_in();
    repeat (5) tick;
    reset_n = 0;
    tick;
    reset_n = 1;
    @(negedge clk);
    chk("rstmid_hi", bus.hi_o, 0);
    chk("rstmid_lo", bus.lo_o, 0);
    chk("rstmid_busy", bus.busy_o, 0);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o) n++;
    end
    chk("rstmid_no_done", n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
